// File: rtl/fetch_queue.sv
// Instruction fetch stage: credit-limited in-order issue to instruction memory,
// a small response FIFO toward decode, and redirect flush that drops stale responses.
module fetch_queue #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter int               PC_INC   = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst_data,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready
);

    localparam int               AW     = $clog2(DEPTH);
    localparam int               CW     = AW + 1;
    localparam logic [WIDTH-1:0] INC    = WIDTH'(PC_INC);
    localparam logic [CW:0]      CREDIT = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]    ONE_C  = CW'(1);
    localparam logic [AW-1:0]    ONE_P  = AW'(1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] pc;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    drop_cnt;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] resp_pc;
    logic             issue;
    logic             resp;
    logic             drop;
    logic             push;
    logic             pop;

    // Queued words plus outstanding requests may never exceed DEPTH, so every
    // non-dropped response is guaranteed a free slot when it lands.
    assign imem_req  = rst_n && !redirect_valid &&
                       (({1'b0, count} + {1'b0, inflight}) < CREDIT);
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_ready;

    assign resp = imem_rvalid && (inflight != '0);
    assign drop = resp && (drop_cnt != '0);
    assign push = resp && !drop && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign inst_data  = inst_valid ? head.data : '0;
    assign inst_pc    = inst_valid ? head.pc   : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + (issue ? ONE_C : '0) - (resp ? ONE_C : '0);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop_cnt <= inflight - (resp ? ONE_C : '0);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + INC;
                if (drop) drop_cnt <= drop_cnt - ONE_C;
                if (push) begin
                    resp_pc <= resp_pc + INC;
                    wr_ptr  <= wr_ptr + ONE_P;
                end
                if (pop) rd_ptr <= rd_ptr + ONE_P;
                count <= count + (push ? ONE_C : '0) - (pop ? ONE_C : '0);
            end
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read after
    // a push wrote it, and the outputs are forced to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: imem_rdata, pc: resp_pc};
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage feeding the decode stage of the 16-bit datapath.
- Owns the fetch program counter and issues in-order reads to instruction memory.
- Buffers returned instruction words and their PCs in a DEPTH-entry FIFO, presented to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes the queue and discards stale in-flight responses.

Parameters:
- WIDTH, 16, instruction word and address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PC_INC, 2, fetch address increment per instruction (byte-addressed, 16-bit words).
- RESET_PC, 16'h0000, fetch PC after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: asynchronous, active-low; single clock domain.
- redirect_valid  input  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  input  WIDTH  new fetch address.
- imem_req  output  1  read request.
- imem_addr  output  WIDTH  read address, valid while imem_req is high.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data returning, in issue order, at least 1 cycle after issue.
- imem_rdata  input  WIDTH  returned instruction word.
- inst_valid  output  1  queue head valid.
- inst_data  output  WIDTH  head instruction.
- inst_pc  output  WIDTH  address of head instruction.
- inst_ready  input  1  decode consumes the head.

Behaviour:
- Reset (rst_n low, asynchronous):
  - fetch_pc = RESET_PC; resp_pc = RESET_PC.
  - Queue empty; inflight = 0; drop_cnt = 0.
  - Outputs: inst_valid = 0, imem_req = 0, inst_data = 0, inst_pc = 0.
- Issue:
  - imem_req = (occupancy + inflight < DEPTH) and not redirect_valid.
  - imem_addr = fetch_pc.
  - An issue happens when imem_req and imem_ready are both high. On issue: fetch_pc += PC_INC (mod 2^WIDTH), inflight += 1.
  - imem_req may stay high with imem_ready low; imem_addr holds stable.
- Response:
  - Each imem_rvalid decrements inflight.
  - If drop_cnt > 0: response is discarded and drop_cnt -= 1.
  - Otherwise: push {imem_rdata, resp_pc} into the FIFO and resp_pc += PC_INC.
  - The credit rule guarantees a push never overflows. An rvalid with inflight = 0 is a protocol error: ignored, and the bench asserts it never happens.
- Output:
  - inst_valid = queue not empty; inst_data and inst_pc come from the head entry.
  - A pop happens when inst_valid and inst_ready are both high.
  - Push and pop in the same cycle are allowed, including when the queue is full (the credit includes the popped slot only on the next cycle) and when it is empty (no bypass: the word appears 1 cycle after rvalid).
- Latency: best case 2 cycles from issue to inst_valid (memory latency 1, plus 1 FIFO register).
- Redirect (redirect_valid high, evaluated at the clock edge):
  - Queue is emptied; pops and pushes that cycle are ignored.
  - fetch_pc = redirect_pc; resp_pc = redirect_pc.
  - No issue that cycle (imem_req forced to 0).
  - drop_cnt = inflight minus (1 if imem_rvalid this cycle else 0); inflight is updated normally.
  - inst_valid is 0 the following cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Wrap-around: fetch_pc, resp_pc, and the FIFO pointers wrap modulo their width; no flag is raised.
- Reset mid-operation: all state clears immediately. In-flight memory responses arriving after reset release are counted as protocol errors; the system holds memory in reset alongside this block.

Test Plan:
- Reset, then imem_ready = 1, memory latency 1, inst_ready = 1 → addresses 0x0000, 0x0002, 0x0004 issued on consecutive cycles; inst_pc 0x0000/0x0002/0x0004 with matching data, first inst_valid 2 cycles after the first issue.
- inst_ready = 0, memory always ready → exactly 4 issues, then imem_req low; queue holds 4 entries, and inflight + occupancy never exceeds 4. Raise inst_ready → one new issue per pop.
- Memory latency 3, 3 requests in flight, redirect to 0x0100 → the 3 stale responses are dropped; next inst_pc = 0x0100 with data from address 0x0100; no stale data is visible.
- Redirect in the same cycle as an rvalid and a pending pop → that rvalid is dropped, no pop occurs, and inst_valid is 0 on the next cycle.
- Redirect to 0xFFFC → inst_pc sequence 0xFFFC, 0xFFFE, 0x0000.
- Assert rst_n low mid-stream with a full queue → inst_valid and imem_req drop immediately (asynchronously); after release, fetch restarts at RESET_PC.
